// File: rtl/uart_tx_async.sv
// UART transmitter: start bit, 7/8 data bits LSB-first, optional parity, one stop bit.
// Every bit lasts 8 baud_clock pulses; the byte comes from a holding register or an external FIFO.
module uart_tx_async #(
  parameter int TX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic [7:0] tx_hold_reg,
  input  logic       write_tx_byte,
  input  logic       fifo_empty,
  output logic       fifo_read_n,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy
);

  localparam bit FIFO_MODE = (TX_FIFO != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic [7:0]  hold_q, hold_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic        fetch_q, fetch_d;
  logic        bit8_q, bit8_d;
  logic        parity_en_q, parity_en_d;
  logic        odd_q, odd_d;

  logic        bit_end;
  logic        data_avail;
  logic        start_frame;
  logic        load_now;
  logic [7:0]  load_byte;
  logic [7:0]  masked_byte;
  logic        cfg_bit8;
  logic        cfg_odd;
  logic [2:0]  last_bit;

  assign bit_end     = baud_clock && (baud_cnt_q == 3'd7);
  assign data_avail  = FIFO_MODE ? !fifo_empty : !ready_q;
  assign start_frame = (state_q == S_IDLE) && baud_clock && data_avail;
  assign last_bit    = bit8_q ? 3'd7 : 3'd6;

  // In FIFO mode the byte arrives two clocks after the frame starts, well before the
  // first data bit is needed, so the configuration used for masking comes from the latches.
  assign load_now    = FIFO_MODE ? fetch_q : start_frame;
  assign load_byte   = FIFO_MODE ? tx_hold_reg : hold_q;
  assign cfg_bit8    = FIFO_MODE ? bit8_q : bit8;
  assign cfg_odd     = FIFO_MODE ? odd_q : odd_n_even;
  assign masked_byte = {load_byte[7] & cfg_bit8, load_byte[6:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      hold_q      <= 8'd0;
      fifo_rd_q   <= 1'b0;
      fetch_q     <= 1'b0;
      bit8_q      <= 1'b1;
      parity_en_q <= 1'b0;
      odd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      hold_q      <= hold_d;
      fifo_rd_q   <= fifo_rd_d;
      fetch_q     <= fetch_d;
      bit8_q      <= bit8_d;
      parity_en_q <= parity_en_d;
      odd_q       <= odd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_frame) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_cnt_q == last_bit)) begin
          state_d = parity_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    ready_d     = ready_q;
    hold_d      = hold_q;
    fifo_rd_d   = 1'b0;
    fetch_d     = 1'b0;
    bit8_d      = bit8_q;
    parity_en_d = parity_en_q;
    odd_d       = odd_q;

    if (baud_clock && (state_q != S_IDLE)) begin
      baud_cnt_d = baud_cnt_q + 3'd1;
    end

    if (start_frame) begin
      bit_cnt_d   = 3'd0;
      bit8_d      = bit8;
      parity_en_d = parity_en;
      odd_d       = odd_n_even;
    end else if ((state_q == S_DATA) && bit_end) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {1'b0, shift_q[7:1]};
    end

    if (load_now) begin
      shift_d  = masked_byte;
      parity_d = (^masked_byte) ^ cfg_odd;
    end

    if (FIFO_MODE) begin
      fifo_rd_d = start_frame;
      fetch_d   = fifo_rd_q;
    end else if (start_frame) begin
      ready_d = 1'b1;
    end else if (write_tx_byte && ready_q) begin
      hold_d  = tx_hold_reg;
      ready_d = 1'b0;
    end

    // The line only moves on baud pulses, taking the value of the state being entered.
    if (baud_clock) begin
      case (state_d)
        S_START:  tx_d = 1'b0;
        S_DATA:   tx_d = shift_d[0];
        S_PARITY: tx_d = parity_q;
        default:  tx_d = 1'b1;
      endcase
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_ready    = FIFO_MODE ? !fifo_empty : ready_q;
  assign fifo_read_n = !fifo_rd_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Self-checking bench for uart_tx_async: holding-register and FIFO instances side by side,
// line checked after every baud pulse against a per-pulse schedule derived from the frame format.
module tb_uart_tx_async;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_clock;
  logic       bit8, parity_en, odd_n_even;
  logic [7:0] hold0, hold1;
  logic       write0;
  logic       no_write1;
  logic       fifo_empty0;
  logic       fifo_empty1;
  logic       fifo_read_n0, tx0, ready0, busy0;
  logic       fifo_read_n1, tx1, ready1, busy1;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  bit exp_tx_q[$];
  bit exp_busy_q[$];

  logic [7:0] fifo_mem [0:7];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_async #(.TX_FIFO(0)) dut_reg (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .tx_hold_reg(hold0), .write_tx_byte(write0), .fifo_empty(fifo_empty0),
    .fifo_read_n(fifo_read_n0), .tx(tx0), .tx_ready(ready0), .tx_busy(busy0)
  );

  uart_tx_async #(.TX_FIFO(1)) dut_fifo (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .tx_hold_reg(hold1), .write_tx_byte(no_write1), .fifo_empty(fifo_empty1),
    .fifo_read_n(fifo_read_n1), .tx(tx1), .tx_ready(ready1), .tx_busy(busy1)
  );

  // FIFO with registered read data: popped word appears the clock after the strobe.
  always @(posedge clk) begin
    if (!fifo_read_n1) begin
      hold1      <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      strobe_cnt <= strobe_cnt + 1;
    end
  end
  assign fifo_empty1 = (rd_ptr == wr_ptr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk);
    baud_clock = 1'b1;
    @(negedge clk);
    baud_clock = 1'b0;
  endtask

  task automatic set_cfg(input bit b8, input bit pen, input bit odd);
    bit8       = b8;
    parity_en  = pen;
    odd_n_even = odd;
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    hold0  = d;
    write0 = 1'b1;
    @(negedge clk);
    write0 = 1'b0;
  endtask

  // Line value after each pulse, counted from the pulse that loads the byte.
  task automatic push_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd);
    int nb;
    int nbits;
    int ones;
    bit par;
    bit v;
    nb    = b8 ? 8 : 7;
    nbits = nb + 2 + (pen ? 1 : 0);
    ones  = 0;
    for (int j = 0; j < nb; j++) ones += int'(d[j]);
    par = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    for (int k = 0; k < nbits * 8; k++) begin
      int i;
      i = k / 8;
      if (i == 0) v = 1'b0;
      else if (i <= nb) v = d[i-1];
      else if (pen && (i == nb + 1)) v = par;
      else v = 1'b1;
      exp_tx_q.push_back(v);
      exp_busy_q.push_back(1'b1);
    end
    exp_tx_q.push_back(1'b1);
    exp_busy_q.push_back(1'b0);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx_q.push_back(1'b1);
      exp_busy_q.push_back(1'b0);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bit et, eb;
      pulse();
      et = exp_tx_q.pop_front();
      eb = exp_busy_q.pop_front();
      chk({tag, "_tx"},   (sel != 0) ? tx1 : tx0, et);
      chk({tag, "_busy"}, (sel != 0) ? busy1 : busy0, eb);
    end
  endtask

  task automatic run_all(input string tag);
    run(exp_tx_q.size(), tag);
  endtask

  initial begin
    logic [7:0] b1, b2, b3, d;
    bit rb8, rpen, rodd;

    reset_n     = 1'b0;
    baud_clock  = 1'b0;
    write0      = 1'b0;
    hold0       = 8'h00;
    no_write1   = 1'b0;
    fifo_empty0 = 1'b1;
    set_cfg(1, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_tx0", tx0, 1);
    chk("rst_ready0", ready0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_rdn0", fifo_read_n0, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_rdn1", fifo_read_n1, 1);
    @(negedge clk);
    reset_n = 1'b1;
    chk("fifo_ready_empty", ready1, 0);

    // 8N1, 0x55
    sel = 0;
    set_cfg(1, 0, 0);
    wr(8'h55);
    chk("s1_ready_clr", ready0, 0);
    push_frame(8'h55, 1, 0, 0);
    run(1, "s1");
    chk("s1_ready_load", ready0, 1);
    push_idle(2);
    run_all("s1");

    // 8E1 then 8O1 of 0xA5; parity select flipped mid-frame must not affect the first
    set_cfg(1, 1, 0);
    wr(8'hA5);
    push_frame(8'hA5, 1, 1, 0);
    run(20, "s2e");
    odd_n_even = 1'b1;
    run_all("s2e");
    wr(8'hA5);
    push_frame(8'hA5, 1, 1, 1);
    push_idle(1);
    run_all("s2o");

    // 7O1, 0xFF: bit 7 dropped, parity 0
    set_cfg(0, 1, 1);
    wr(8'hFF);
    push_frame(8'hFF, 0, 1, 1);
    push_idle(1);
    run_all("s3");

    // back-to-back frames; third write while full is dropped
    set_cfg(1, 0, 0);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = ~b2;
    wr(b1);
    push_frame(b1, 1, 0, 0);
    push_frame(b2, 1, 0, 0);
    push_idle(4);
    run(21, "s4");
    wr(b2);
    chk("s4_ready_full", ready0, 0);
    wr(b3);
    chk("s4_drop", ready0, 0);
    run_all("s4");
    chk("s4_ready_end", ready0, 1);

    // random frames with configuration scrambled after each load
    for (int n = 0; n < 5; n++) begin
      d    = 8'($urandom);
      rb8  = 1'($urandom_range(0, 1));
      rpen = 1'($urandom_range(0, 1));
      rodd = 1'($urandom_range(0, 1));
      set_cfg(rb8, rpen, rodd);
      wr(d);
      push_frame(d, rb8, rpen, rodd);
      push_idle($urandom_range(1, 3));
      run(1, "s5");
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_all("s5");
    end

    // FIFO mode, three entries, 8O1
    sel = 1;
    set_cfg(1, 1, 1);
    chk("s6_strobe_none", strobe_cnt, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) fifo_mem[i] = 8'($urandom);
    wr_ptr = 3;
    @(negedge clk);
    chk("s6_ready_data", ready1, 1);
    for (int i = 0; i < 3; i++) push_frame(fifo_mem[i], 1, 1, 1);
    push_idle(6);
    run_all("s6");
    chk("s6_strobes", strobe_cnt, 3);
    chk("s6_empty", fifo_empty1, 1);
    chk("s6_ready_end", ready1, 0);

    // asynchronous reset in the middle of a data bit
    sel = 0;
    set_cfg(1, 0, 0);
    wr(8'h00);
    push_frame(8'h00, 1, 0, 0);
    run(20, "s7");
    exp_tx_q.delete();
    exp_busy_q.delete();
    chk("s7_pre_tx", tx0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("s7_rst_tx", tx0, 1);
    chk("s7_rst_busy", busy0, 0);
    chk("s7_rst_ready", ready0, 1);
    @(negedge clk);
    reset_n = 1'b1;
    push_idle(60);
    run_all("s7_post");
    chk("s7_ready_post", ready0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
